// File: rtl/nco_pkg.sv
// nco_pkg: shared constants and FSM state type for the NCO sweep controller
package nco_pkg;
  localparam int CW_WIDTH = 32;
  localparam int MODE_CONT = 0;
  localparam int MODE_TRI = 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, DWELL, DONE} state_t;
endpackage

// File: rtl/nco_sweep_step.sv
// nco_sweep_step: clamped step of a control word toward a target, never wrapping
// ports: control/step/target words in, dir (1 = up) in; next word and at_target out
module nco_sweep_step #(
  parameter int CW_WIDTH = 32
) (
  input  logic [CW_WIDTH-1:0] control,
  input  logic [CW_WIDTH-1:0] step,
  input  logic [CW_WIDTH-1:0] target,
  input  logic                dir,
  output logic [CW_WIDTH-1:0] next,
  output logic                at_target
);
  logic [CW_WIDTH:0] sum, diff;
  logic              past_up, past_dn;
  assign sum = {1'b0, control} + {1'b0, step};
  assign diff = {1'b0, control} - {1'b0, step};
  // a zero step means "jump straight to target"; diff[CW_WIDTH] flags a borrow
  assign past_up = step == '0 || sum > {1'b0, target};
  assign past_dn = step == '0 || diff[CW_WIDTH] || diff[CW_WIDTH-1:0] < target;
  assign next = dir ? (past_up ? target : sum[CW_WIDTH-1:0])
                    : (past_dn ? target : diff[CW_WIDTH-1:0]);
  assign at_target = control == target;
endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: sweeps the NCO frequency word from start_word to stop_word
// ports: clk/reset; start/abort and sweep settings in; control word, nco_reset pulse,
//        busy and done pulse out, all registered
module nco_sweep_ctrl #(
  parameter int CW_WIDTH = nco_pkg::CW_WIDTH,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CW_WIDTH-1:0]    start_word,
  input  logic [CW_WIDTH-1:0]    stop_word,
  input  logic [CW_WIDTH-1:0]    step_word,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic [1:0]             mode,
  output logic [CW_WIDTH-1:0]    control,
  output logic                   nco_reset,
  output logic                   busy,
  output logic                   done
);
  import nco_pkg::*;
  state_t                 state_q, state_d;
  logic [CW_WIDTH-1:0]    control_q, control_d, start_q, start_d, stop_q, stop_d;
  logic [CW_WIDTH-1:0]    step_q, step_d, tgt_q, tgt_d, nxt, bnc_nxt;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
  logic [1:0]             mode_q, mode_d;
  logic                   nco_reset_q, nco_reset_d, busy_q, busy_d, done_q, done_d;
  logic                   dir_q, dir_d, ret_q, ret_d, at_tgt, bounce;
  nco_sweep_step #(.CW_WIDTH(CW_WIDTH)) u_step (
    .control(control_q), .step(step_q), .target(tgt_q), .dir(dir_q),
    .next(nxt), .at_target(at_tgt)
  );
  // step toward the opposite end, used when a triangle sweep bounces
  nco_sweep_step #(.CW_WIDTH(CW_WIDTH)) u_bounce (
    .control(control_q), .step(step_q), .target(ret_q ? stop_q : start_q), .dir(~dir_q),
    .next(bnc_nxt), .at_target()
  );
  // a degenerate triangle (start == stop) has no outbound leg to bounce from
  assign bounce = mode_q[MODE_TRI] && ((!ret_q && start_q != stop_q) || mode_q[MODE_CONT]);
  always_comb begin
    state_d = state_q;
    control_d = control_q;
    start_d = start_q;
    stop_d = stop_q;
    step_d = step_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    dwell_d = dwell_q;
    mode_d = mode_q;
    dir_d = dir_q;
    ret_d = ret_q;
    busy_d = busy_q;
    nco_reset_d = 1'b0;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        start_d = start_word;
        stop_d = stop_word;
        step_d = step_word;
        dwell_d = dwell;
        mode_d = mode;
        tgt_d = stop_word;
        dir_d = stop_word >= start_word;
        ret_d = 1'b0;
        state_d = LAUNCH;
      end
    end else if (abort) begin
      state_d = IDLE;
      busy_d = 1'b0;
    end else if (state_q == LAUNCH) begin
      control_d = start_q;
      nco_reset_d = 1'b1;
      busy_d = 1'b1;
      cnt_d = dwell_q;
      state_d = DWELL;
    end else if (state_q == DWELL) begin
      if (cnt_q != '0) cnt_d = cnt_q - DWELL_WIDTH'(1);
      else if (!at_tgt) begin
        control_d = nxt;
        cnt_d = dwell_q;
      end else if (bounce) begin
        tgt_d = ret_q ? stop_q : start_q;
        dir_d = ~dir_q;
        ret_d = ~ret_q;
        control_d = bnc_nxt;
        cnt_d = dwell_q;
      end else if (mode_q == 2'b01) begin
        control_d = start_q;
        cnt_d = dwell_q;
      end else begin
        state_d = DONE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      control_q <= '0;
      start_q <= '0;
      stop_q <= '0;
      step_q <= '0;
      tgt_q <= '0;
      cnt_q <= '0;
      dwell_q <= '0;
      mode_q <= '0;
      dir_q <= 1'b0;
      ret_q <= 1'b0;
      busy_q <= 1'b0;
      nco_reset_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      control_q <= control_d;
      start_q <= start_d;
      stop_q <= stop_d;
      step_q <= step_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
      dwell_q <= dwell_d;
      mode_q <= mode_d;
      dir_q <= dir_d;
      ret_q <= ret_d;
      busy_q <= busy_d;
      nco_reset_q <= nco_reset_d;
      done_q <= done_d;
    end
  end
  assign control = control_q;
  assign nco_reset = nco_reset_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: scoreboard bench for the NCO sweep controller
module tb_nco_sweep_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] start_word = '0, stop_word = '0, step_word = '0;
  logic [15:0] dwell = '0;
  logic [1:0]  mode = '0;
  logic [31:0] control;
  logic        nco_reset, busy, done;
  int          total = 0, bad = 0;
  logic [31:0] exp_q[$];

  nco_sweep_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .start_word(start_word), .stop_word(stop_word), .step_word(step_word),
    .dwell(dwell), .mode(mode), .control(control), .nco_reset(nco_reset),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w);
  endtask

  task automatic launch(input logic [31:0] sw, ew, st, input logic [15:0] dw, input logic [1:0] md);
    @(negedge clk);
    start_word = sw;
    stop_word = ew;
    step_word = st;
    dwell = dw;
    mode = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_run(input string name, input int n, input bit exp_done, input int poke);
    logic [31:0] w, last;
    last = control;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w = exp_q.pop_front();
      last = w;
      total++;
      if (control !== w) begin bad++; $display("FAIL %s word[%0d] got=%0h want=%0h", name, i, control, w); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL %s busy[%0d] got=%b want=1", name, i, busy); end
      total++;
      if (nco_reset !== 1'(i == 0)) begin bad++; $display("FAIL %s nco_reset[%0d] got=%b want=%b", name, i, nco_reset, i == 0); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL %s early_done[%0d] got=%b want=0", name, i, done); end
      if (i == poke) begin
        start_word = 32'd7;
        mode = 2'b01;
      end
      start = (i == poke);
    end
    start = 1'b0;
    if (exp_done) begin
      @(negedge clk);
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL %s done got=%b want=1", name, done); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done got=%b want=0", name, busy); end
      total++;
      if (control !== last) begin bad++; $display("FAIL %s hold_at_done got=%0h want=%0h", name, control, last); end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL %s done_pulse got=%b want=0", name, done); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_idle got=%b want=0", name, busy); end
    end
  endtask

  task automatic do_abort(input string name, input logic [31:0] hold);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy got=%b want=0", name, busy); end
    total++;
    if (control !== hold) begin bad++; $display("FAIL %s hold got=%0h want=%0h", name, control, hold); end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s idle got done=%b busy=%b want 0/0", name, done, busy); end
      total++;
      if (control !== hold) begin bad++; $display("FAIL %s idle_hold got=%0h want=%0h", name, control, hold); end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (control !== 32'd0) begin bad++; $display("FAIL reset control got=%0h want=0", control); end
    total++;
    if ({nco_reset, busy, done} !== 3'b000) begin bad++; $display("FAIL reset flags got=%b want=000", {nco_reset, busy, done}); end
    reset = 1'b0;
  endtask

  task automatic test_up_oneshot;
    launch(32'd100, 32'd400, 32'd100, 16'd1, 2'b00);
    push(32'd100, 2); push(32'd200, 2); push(32'd300, 2); push(32'd400, 2);
    check_run("up", 8, 1'b1, -1);
  endtask

  task automatic test_clamp;
    launch(32'd0, 32'd250, 32'd100, 16'd0, 2'b00);
    push(32'd0, 1); push(32'd100, 1); push(32'd200, 1); push(32'd250, 1);
    check_run("clamp", 4, 1'b1, -1);
  endtask

  task automatic test_down;
    launch(32'hFFFF_FFF0, 32'h10, 32'h4000_0000, 16'd0, 2'b00);
    push(32'hFFFF_FFF0, 1); push(32'hBFFF_FFF0, 1); push(32'h7FFF_FFF0, 1);
    push(32'h3FFF_FFF0, 1); push(32'h10, 1);
    check_run("down", 5, 1'b1, -1);
  endtask

  task automatic test_triangle;
    launch(32'd0, 32'd2, 32'd1, 16'd0, 2'b10);
    push(0, 1); push(1, 1); push(2, 1); push(1, 1); push(0, 1);
    check_run("tri", 5, 1'b1, -1);
    launch(32'd0, 32'd2, 32'd1, 16'd0, 2'b11);
    push(0, 1); push(1, 1); push(2, 1); push(1, 1); push(0, 1);
    push(1, 1); push(2, 1); push(1, 1); push(0, 1);
    check_run("tri_cont", 9, 1'b0, -1);
    do_abort("tri_abort", 32'd0);
  endtask

  task automatic test_continuous;
    launch(32'd5, 32'd7, 32'd1, 16'd0, 2'b01);
    push(5, 1); push(6, 1); push(7, 1); push(5, 1); push(6, 1); push(7, 1); push(5, 1);
    check_run("cont", 7, 1'b0, -1);
    do_abort("cont_abort", 32'd5);
  endtask

  task automatic test_back_to_back;
    launch(32'd100, 32'd400, 32'd100, 16'd1, 2'b00);
    push(32'd100, 2); push(32'd200, 2); push(32'd300, 2); push(32'd400, 2);
    check_run("busy_start", 8, 1'b1, 2);
  endtask

  task automatic test_abort;
    launch(32'd100, 32'd400, 32'd100, 16'd1, 2'b00);
    push(32'd100, 2); push(32'd200, 1);
    check_run("pre_abort", 3, 1'b0, -1);
    do_abort("abort", 32'd200);
  endtask

  task automatic test_reset_mid;
    launch(32'd100, 32'd400, 32'd100, 16'd1, 2'b00);
    push(32'd100, 2); push(32'd200, 1);
    check_run("pre_reset", 3, 1'b0, -1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (control !== 32'd0) begin bad++; $display("FAIL mid_reset control got=%0h want=0", control); end
    total++;
    if ({nco_reset, busy, done} !== 3'b000) begin bad++; $display("FAIL mid_reset flags got=%b want=000", {nco_reset, busy, done}); end
  endtask

  task automatic test_equal_with_abort;
    abort = 1'b1;
    launch(32'd9, 32'd9, 32'd5, 16'd1, 2'b10);
    abort = 1'b0;
    push(32'd9, 2);
    check_run("equal", 2, 1'b1, -1);
  endtask

  initial begin
    test_reset;
    test_up_oneshot;
    test_clamp;
    test_down;
    test_triangle;
    test_continuous;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_equal_with_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
